// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared sizes and write-buffer entry type for the data-port responder
package data_memory_responder_pkg;
  localparam int DATA_WIDTH = 20;
  localparam int ADDR_BITS  = 8;
  localparam int WBUF_DEPTH = 4;
  localparam int MEM_AW     = 20;
  localparam int PTR_W      = $clog2(WBUF_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: processor data-port bus plus preload port and buffer status
//   master drives mem_address/mem_wdata/mem_we and load_en/load_addr/load_data,
//   slave returns data_in_mem, stall, overflow and buffer_count.
interface data_memory_responder_if;
  import data_memory_responder_pkg::*;
  logic [MEM_AW-1:0]     mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] data_in_mem;
  logic                  load_en;
  logic [ADDR_BITS-1:0]  load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  stall;
  logic                  overflow;
  logic [CNT_W-1:0]      buffer_count;
  modport master (
    output mem_address, mem_wdata, mem_we, load_en, load_addr, load_data,
    input  data_in_mem, stall, overflow, buffer_count
  );
  modport slave (
    input  mem_address, mem_wdata, mem_we, load_en, load_addr, load_data,
    output data_in_mem, stall, overflow, buffer_count
  );
endinterface

// File: rtl/data_memory_responder_write_buffer_fifo.sv
// write_buffer_fifo: circular posted-store buffer with youngest-match forwarding lookup
//   i_clk, i_rst_n     clock, async active-low reset
//   i_enq, i_entry     accepted store and its {addr,data}
//   i_deq              head entry is being drained this edge
//   i_addr             lookup address for forwarding
//   o_head             oldest entry, o_count valid entries
//   o_hit, o_hit_data  youngest valid entry matching i_addr
module write_buffer_fifo
  import data_memory_responder_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enq,
  input  wbuf_entry_t           i_entry,
  input  logic                  i_deq,
  input  logic [ADDR_BITS-1:0]  i_addr,
  output wbuf_entry_t           o_head,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_hit,
  output logic [DATA_WIDTH-1:0] o_hit_data
);
  wbuf_entry_t      r_mem [WBUF_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail, w_idx;
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_tail <= r_tail + PTR_W'(1);
      if (i_deq) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_enq) - CNT_W'(i_deq);
    end
  always_ff @(posedge i_clk)
    if (i_enq) r_mem[r_tail] <= i_entry;
  // Walk oldest to youngest so the youngest match is the last one to win.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int i = WBUF_DEPTH - 1; i >= 0; i--) begin
      w_idx = r_tail - PTR_W'(i + 1);
      if (CNT_W'(i) < r_count && r_mem[w_idx].addr == i_addr) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[w_idx].data;
      end
    end
  end
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word RAM behind a posted write buffer with store-to-load forwarding and preload
//   i_clk, i_rst_n  clock, async active-low reset
//   bus             slave side of data_memory_responder_if (data port, preload, status)
module data_memory_responder
  import data_memory_responder_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  data_memory_responder_if.slave   bus
);
  logic [DATA_WIDTH-1:0] r_ram [2**ADDR_BITS];
  logic                  r_overflow;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full, w_drain, w_enq, w_hit, w_unused;
  logic [DATA_WIDTH-1:0] w_hit_data;
  wbuf_entry_t           w_head;
  assign w_addr   = bus.mem_address[ADDR_BITS-1:0];
  assign w_unused = ^bus.mem_address[MEM_AW-1:ADDR_BITS];
  assign w_full   = w_count == CNT_W'(WBUF_DEPTH);
  assign w_drain  = w_count != '0 && !bus.load_en;
  // A full buffer still accepts a store when the head frees a slot on the same edge.
  assign w_enq    = bus.mem_we && (!w_full || w_drain);
  write_buffer_fifo u_wbuf (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enq      (w_enq),
    .i_entry    ('{addr: w_addr, data: bus.mem_wdata}),
    .i_deq      (w_drain),
    .i_addr     (w_addr),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_hit      (w_hit),
    .o_hit_data (w_hit_data)
  );
  // Preload owns the single RAM write port; draining waits while it is active.
  always_ff @(posedge i_clk)
    if (bus.load_en) r_ram[bus.load_addr] <= bus.load_data;
    else if (w_drain) r_ram[w_head.addr] <= w_head.data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_overflow <= 1'b0;
    else if (bus.mem_we && !w_enq) r_overflow <= 1'b1;
  assign bus.data_in_mem  = w_hit ? w_hit_data : r_ram[w_addr];
  assign bus.stall        = w_full;
  assign bus.overflow     = r_overflow;
  assign bus.buffer_count = w_count;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed scenario bench for data_memory_responder
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;
  logic clk = 0, rst_n = 0;
  int tests = 0, fails = 0;
  data_memory_responder_if bus();
  data_memory_responder dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.mem_we = 0; bus.load_en = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [19:0] d);
    bus.load_en = 1; bus.load_addr = a; bus.load_data = d; bus.mem_we = 0;
    tick(); bus.load_en = 0;
  endtask

  task automatic test_reset();
    bus.mem_address = 0; bus.mem_wdata = 0; bus.load_addr = 0; bus.load_data = 0; idle();
    #1;
    tests++; if (bus.buffer_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.buffer_count); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    tick(); tick(); rst_n = 1; tick();
  endtask

  task automatic test_preload_alias();
    preload(8'd5, 20'h0ABCD);
    bus.mem_address = 20'h00005; #1;
    tests++; if (bus.data_in_mem !== 20'h0ABCD) begin fails++; $display("FAIL preload_read got %h want 0abcd", bus.data_in_mem); end
    bus.mem_address = 20'hFF005; #1;
    tests++; if (bus.data_in_mem !== 20'h0ABCD) begin fails++; $display("FAIL alias_read got %h want 0abcd", bus.data_in_mem); end
  endtask

  task automatic test_store_forward();
    preload(8'd7, 20'h00777);
    bus.mem_address = 20'd7; bus.mem_wdata = 20'h12345; bus.mem_we = 1; #1;
    tests++; if (bus.data_in_mem !== 20'h00777) begin fails++; $display("FAIL same_cycle_read got %h want 00777", bus.data_in_mem); end
    tick(); bus.mem_we = 0; #1;
    tests++; if (bus.data_in_mem !== 20'h12345) begin fails++; $display("FAIL forward_read got %h want 12345", bus.data_in_mem); end
    tests++; if (bus.buffer_count !== 3'd1) begin fails++; $display("FAIL forward_count got %0d want 1", bus.buffer_count); end
    tick();
    tests++; if (bus.buffer_count !== 3'd0) begin fails++; $display("FAIL drained_count got %0d want 0", bus.buffer_count); end
    tests++; if (bus.data_in_mem !== 20'h12345) begin fails++; $display("FAIL drained_read got %h want 12345", bus.data_in_mem); end
  endtask

  task automatic test_youngest_match();
    bus.load_en = 1; bus.load_addr = 8'd3; bus.load_data = 20'h00333;
    bus.mem_address = 20'd3; bus.mem_wdata = 20'd1; bus.mem_we = 1;
    tick();
    bus.load_addr = 8'h20; bus.load_data = 20'd0; bus.mem_wdata = 20'd2;
    tick(); bus.mem_we = 0; #1;
    tests++; if (bus.data_in_mem !== 20'd2) begin fails++; $display("FAIL youngest_read got %h want 2", bus.data_in_mem); end
    tests++; if (bus.buffer_count !== 3'd2) begin fails++; $display("FAIL youngest_count got %0d want 2", bus.buffer_count); end
    bus.load_en = 0; tick();
    tests++; if (bus.data_in_mem !== 20'd2 || bus.buffer_count !== 3'd1) begin fails++; $display("FAIL partial_drain got %h/%0d want 2/1", bus.data_in_mem, bus.buffer_count); end
    tick();
    tests++; if (bus.data_in_mem !== 20'd2 || bus.buffer_count !== 3'd0) begin fails++; $display("FAIL ram3_after_drain got %h/%0d want 2/0", bus.data_in_mem, bus.buffer_count); end
  endtask

  task automatic test_overflow();
    preload(8'h44, 20'h0DEAD);
    bus.load_en = 1; bus.load_addr = 8'h30; bus.load_data = 20'd0; bus.mem_we = 1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_address = 20'h40 + k; bus.mem_wdata = 20'h100 + k; tick();
    end
    tests++; if (bus.stall !== 1'b1 || bus.buffer_count !== 3'd4) begin fails++; $display("FAIL full_state got stall=%b cnt=%0d want 1/4", bus.stall, bus.buffer_count); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL pre_overflow got %b want 0", bus.overflow); end
    bus.mem_address = 20'h44; bus.mem_wdata = 20'h104; tick(); bus.mem_we = 0; #1;
    tests++; if (bus.overflow !== 1'b1 || bus.buffer_count !== 3'd4) begin fails++; $display("FAIL overflow_set got ov=%b cnt=%0d want 1/4", bus.overflow, bus.buffer_count); end
    tests++; if (bus.data_in_mem !== 20'h0DEAD) begin fails++; $display("FAIL dropped_not_fwd got %h want 0dead", bus.data_in_mem); end
    bus.load_en = 0;
    for (int k = 3; k >= 0; k--) begin
      tick();
      tests++; if (bus.buffer_count !== 3'(k)) begin fails++; $display("FAIL drain_step got %0d want %0d", bus.buffer_count, k); end
    end
    for (int k = 0; k < 4; k++) begin
      bus.mem_address = 20'h40 + k; #1;
      tests++; if (bus.data_in_mem !== 20'h100 + k) begin fails++; $display("FAIL drained_entry got %h want %h", bus.data_in_mem, 20'h100 + k); end
    end
    tests++; if (bus.overflow !== 1'b1 || bus.stall !== 1'b0) begin fails++; $display("FAIL overflow_sticky got ov=%b stall=%b want 1/0", bus.overflow, bus.stall); end
  endtask

  task automatic test_full_drain_accept();
    #2 rst_n = 0; #1 rst_n = 1; tick();
    bus.load_en = 1; bus.load_addr = 8'h30; bus.mem_we = 1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_address = 20'h50 + k; bus.mem_wdata = 20'h200 + k; tick();
    end
    bus.load_en = 0; bus.mem_address = 20'h54; bus.mem_wdata = 20'h204;
    tick(); bus.mem_we = 0; #1;
    tests++; if (bus.buffer_count !== 3'd4 || bus.stall !== 1'b1) begin fails++; $display("FAIL full_accept got cnt=%0d stall=%b want 4/1", bus.buffer_count, bus.stall); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL full_accept_ov got %b want 0", bus.overflow); end
    tests++; if (bus.data_in_mem !== 20'h204) begin fails++; $display("FAIL full_accept_fwd got %h want 00204", bus.data_in_mem); end
    bus.mem_address = 20'h50; #1;
    tests++; if (bus.data_in_mem !== 20'h200) begin fails++; $display("FAIL head_in_ram got %h want 00200", bus.data_in_mem); end
    repeat (4) tick();
    bus.mem_address = 20'h54; #1;
    tests++; if (bus.buffer_count !== 3'd0 || bus.data_in_mem !== 20'h204) begin fails++; $display("FAIL full_accept_drain got cnt=%0d d=%h want 0/00204", bus.buffer_count, bus.data_in_mem); end
  endtask

  task automatic test_reset_mid();
    preload(8'h60, 20'h300); preload(8'h61, 20'h301); preload(8'h62, 20'h302);
    bus.load_en = 1; bus.load_addr = 8'h70; bus.load_data = 0; bus.mem_we = 1;
    for (int k = 0; k < 3; k++) begin
      bus.mem_address = 20'h60 + k; bus.mem_wdata = 20'h3F0 + k; tick();
    end
    bus.mem_we = 0; bus.mem_address = 20'h60; #1;
    tests++; if (bus.buffer_count !== 3'd3 || bus.data_in_mem !== 20'h3F0) begin fails++; $display("FAIL pending_state got cnt=%0d d=%h want 3/003f0", bus.buffer_count, bus.data_in_mem); end
    #1 rst_n = 0; #1;
    tests++; if (bus.buffer_count !== 3'd0 || bus.stall !== 1'b0) begin fails++; $display("FAIL async_reset got cnt=%0d stall=%b want 0/0", bus.buffer_count, bus.stall); end
    tests++; if (bus.data_in_mem !== 20'h300) begin fails++; $display("FAIL reset_read60 got %h want 00300", bus.data_in_mem); end
    bus.mem_address = 20'h62; #1;
    tests++; if (bus.data_in_mem !== 20'h302) begin fails++; $display("FAIL reset_read62 got %h want 00302", bus.data_in_mem); end
    bus.mem_address = 20'd7; #1;
    tests++; if (bus.data_in_mem !== 20'h12345) begin fails++; $display("FAIL ram_kept got %h want 12345", bus.data_in_mem); end
    bus.load_en = 0; tick(); rst_n = 1; tick();
  endtask

  initial begin
    test_reset();
    test_preload_alias();
    test_store_forward();
    test_youngest_match();
    test_overflow();
    test_full_drain_accept();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
